// File: rtl/and_gate_pipe.sv
// Registered, optionally pipelined bitwise AND with valid tracking
// and a saturating counter of all-ones results.
module and_gate_pipe #(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             out_all,
    output logic [CNT_W-1:0] hit_count
);

    if (WIDTH < 1 || LATENCY < 1 || CNT_W < 1) begin : g_bad_cfg
        $error("and_gate_pipe: WIDTH, LATENCY and CNT_W must be >= 1");
    end

    localparam int                LAST    = LATENCY - 1;
    localparam logic [CNT_W-1:0]  CNT_ONE = 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    logic [LATENCY-1:0][WIDTH-1:0] data_q;
    logic [LATENCY-1:0][WIDTH-1:0] data_d;
    logic [LATENCY-1:0]            vld_q;
    logic [LATENCY-1:0]            vld_d;
    logic [CNT_W-1:0]              hit_q;
    logic [CNT_W-1:0]              hit_d;

    always_comb begin
        data_d    = data_q;
        vld_d     = vld_q;
        hit_d     = hit_q;
        data_d[0] = a & b;
        vld_d[0]  = in_valid;
        for (int i = 1; i < LATENCY; i++) begin
            data_d[i] = data_q[i-1];
            vld_d[i]  = vld_q[i-1];
        end
        // The final stage doubles as the output hold register.
        if (!vld_d[LAST]) begin
            data_d[LAST] = data_q[LAST];
        end
        if (vld_d[LAST] && (&data_d[LAST]) && (hit_q != CNT_MAX)) begin
            hit_d = hit_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            vld_q  <= '0;
            hit_q  <= '0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            hit_q  <= hit_d;
        end
    end

    assign out       = data_q[LAST];
    assign out_valid = vld_q[LAST];
    assign out_all   = &data_q[LAST];
    assign hit_count = hit_q;

endmodule

// File: tb/tb_and_gate_pipe.sv
// Bench for and_gate_pipe: directed tables, corner sequences and
// randomized traffic against a time-indexed history model.
module tb_and_gate_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic       a1 = 1'b0, b1 = 1'b0, v1 = 1'b0;
    logic       o1, ov1, oa1;
    logic [15:0] h1;

    logic [7:0] a8 = '0, b8 = '0;
    logic       v8 = 1'b0;
    logic [7:0] o8;
    logic       ov8, oa8;
    logic [15:0] h8;

    logic [1:0] as = '0, bs = '0;
    logic       vs = 1'b0;
    logic [1:0] os;
    logic       ovs, oas;
    logic [1:0] hs;

    and_gate_pipe #(.WIDTH(1), .LATENCY(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
        .out(o1), .out_valid(ov1), .out_all(oa1), .hit_count(h1)
    );

    and_gate_pipe #(.WIDTH(8), .LATENCY(3), .CNT_W(16)) u8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8),
        .out(o8), .out_valid(ov8), .out_all(oa8), .hit_count(h8)
    );

    and_gate_pipe #(.WIDTH(2), .LATENCY(2), .CNT_W(2)) us (
        .clk(clk), .rst(rst), .a(as), .b(bs), .in_valid(vs),
        .out(os), .out_valid(ovs), .out_all(oas), .hit_count(hs)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic a;
        logic b;
        logic y;
    } tt_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       all;
    } mb_t;

    tt_t tt[4];
    mb_t mb[3];

    logic [7:0] h8d[400];
    bit         h8v[400];
    logic [1:0] hsd[400];
    bit         hsv[400];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tt[0] = '{1'b0, 1'b0, 1'b0};
        tt[1] = '{1'b0, 1'b1, 1'b0};
        tt[2] = '{1'b1, 1'b0, 1'b0};
        tt[3] = '{1'b1, 1'b1, 1'b1};
        mb[0] = '{8'hF0, 8'h3C, 8'h30, 1'b0};
        mb[1] = '{8'hFF, 8'hFF, 8'hFF, 1'b1};
        mb[2] = '{8'hAA, 8'h55, 8'h00, 1'b0};

        rst = 1'b1;
        tick();
        tick();
        chk("rst_o1", 32'(o1), 0);
        chk("rst_ov1", 32'(ov1), 0);
        chk("rst_oa1", 32'(oa1), 0);
        chk("rst_h1", 32'(h1), 0);
        chk("rst_o8", 32'(o8), 0);
        chk("rst_ov8", 32'(ov8), 0);
        chk("rst_h8", 32'(h8), 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            a1 = tt[i].a;
            b1 = tt[i].b;
            v1 = 1'b1;
            tick();
            chk("tt_out", 32'(o1), 32'(tt[i].y));
            chk("tt_ov", 32'(ov1), 1);
            chk("tt_all", 32'(oa1), 32'(tt[i].y));
            v1 = 1'b0;
            for (int j = 0; j < 9; j++) begin
                tick();
                chk("tt_ov_gap", 32'(ov1), 0);
            end
            chk("tt_hold", 32'(o1), 32'(tt[i].y));
        end
        chk("tt_hits", 32'(h1), 1);

        a1 = 1'b0;
        b1 = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("hold_ov", 32'(ov1), 0);
        end
        chk("hold_out", 32'(o1), 1);
        chk("hold_hits", 32'(h1), 1);

        for (int i = 0; i < 3; i++) begin
            a8 = mb[i].a;
            b8 = mb[i].b;
            v8 = 1'b1;
            tick();
            if (i < 2) chk("mb_early_ov", 32'(ov8), 0);
        end
        v8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mb_ov", 32'(ov8), 1);
            chk("mb_out", 32'(o8), 32'(mb[i].y));
            chk("mb_all", 32'(oa8), 32'(mb[i].all));
            tick();
        end
        chk("mb_ov_end", 32'(ov8), 0);
        chk("mb_hold", 32'(o8), 0);
        chk("mb_hits", 32'(h8), 1);

        a8 = 8'hFF;
        b8 = 8'hFF;
        v8 = 1'b1;
        tick();
        tick();
        v8 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("midrst_ov", 32'(ov8), 0);
            tick();
        end
        chk("midrst_out", 32'(o8), 0);
        chk("midrst_hits", 32'(h8), 0);

        a1 = 1'b1;
        b1 = 1'b1;
        v1 = 1'b1;
        rst = 1'b1;
        tick();
        chk("prio_ov0", 32'(ov1), 0);
        rst = 1'b0;
        v1 = 1'b0;
        tick();
        chk("prio_ov1", 32'(ov1), 0);
        chk("prio_out", 32'(o1), 0);
        chk("prio_hits", 32'(h1), 0);

        as = 2'b11;
        bs = 2'b11;
        for (int i = 0; i < 6; i++) begin
            vs = (i < 5);
            tick();
            if (i >= 1) chk("sat_hits", 32'(hs), 32'((i < 3) ? i : 3));
        end
        vs = 1'b0;

        begin
            int         last_rst;
            logic [7:0] e8o;
            int         e8h;
            bit         e8v;
            logic [1:0] eso;
            int         esh;
            bit         esv;
            bit         r;
            last_rst = 0;
            e8o = '0;
            e8h = 0;
            eso = '0;
            esh = 0;
            for (int k = 0; k < 400; k++) begin
                r = (k == 0) || ($urandom_range(0, 39) == 0);
                rst = r;
                v8 = 1'($urandom);
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    a8 = 8'hFF;
                    b8 = 8'hFF;
                end
                vs = 1'($urandom);
                as = 2'($urandom);
                bs = 2'($urandom);
                h8v[k] = v8;
                h8d[k] = a8 & b8;
                hsv[k] = vs;
                hsd[k] = as & bs;
                tick();
                e8v = 1'b0;
                esv = 1'b0;
                if (r) begin
                    last_rst = k;
                    e8o = '0;
                    e8h = 0;
                    eso = '0;
                    esh = 0;
                end else begin
                    if (k - 2 > last_rst) e8v = h8v[k-2];
                    if (k - 1 > last_rst) esv = hsv[k-1];
                    if (e8v) begin
                        e8o = h8d[k-2];
                        if (e8o == 8'hFF && e8h < 65535) e8h++;
                    end
                    if (esv) begin
                        eso = hsd[k-1];
                        if (eso == 2'b11 && esh < 3) esh++;
                    end
                end
                chk("rnd8_ov", 32'(ov8), 32'(e8v));
                chk("rnd8_out", 32'(o8), 32'(e8o));
                chk("rnd8_all", 32'(oa8), 32'(e8o == 8'hFF));
                chk("rnd8_hits", 32'(h8), 32'(e8h));
                chk("rnds_ov", 32'(ovs), 32'(esv));
                chk("rnds_out", 32'(os), 32'(eso));
                chk("rnds_all", 32'(oas), 32'(eso == 2'b11));
                chk("rnds_hits", 32'(hs), 32'(esh));
            end
            rst = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/and_gate_pipe.md
Name: and_gate_pipe

Overview:
- Registered, optionally pipelined bitwise AND of two operand vectors, with valid tracking and a saturating hit counter.
- Replaces a purely combinational AND gate where timing isolation is needed. Sits between two synchronous producers and any consumer that samples out/out_valid.
- With WIDTH=1, the result matches the 2-input AND truth table: 00->0, 01->0, 10->0, 11->1.

Parameters:
- WIDTH, 1, operand and result width in bits (>=1).
- LATENCY, 1, clock cycles from an input sample to its result on out (>=1).
- CNT_W, 16, width of hit_count (>=1).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  qualifies a/b in the current cycle.
- out  output  WIDTH  registered result a & b.
- out_valid  output  1  high for exactly one cycle per accepted valid beat.
- out_all  output  1  reduction AND of out (all result bits 1).
- hit_count  output  CNT_W  count of valid results with all bits 1, saturating.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All pipeline stage data and valid bits clear to 0; out=0, out_valid=0, out_all=0, hit_count=0.
  - rst has priority over in_valid in the same cycle; that beat is discarded.
  - Reset mid-operation discards every in-flight beat. No out_valid pulse occurs for those beats after reset releases.
- Pipeline:
  - Stage 1 captures a & b and in_valid every cycle.
  - Stages 2..LATENCY shift unconditionally each cycle. There is no stall and no backpressure.
  - A beat presented at edge N appears with out_valid=1 after edge N+LATENCY-1. In other words, it is visible in the cycle following the LATENCY-th edge that includes the capture edge.
  - Back-to-back valid beats produce back-to-back out_valid pulses, in order, with none lost or duplicated.
- Output hold:
  - out updates only when the final stage carries a valid beat.
  - Otherwise out keeps the last valid result, so it is stable between pulses.
  - out_valid reflects the final stage valid bit directly.
- out_all:
  - Combinational reduction AND of the out register.
  - Equals out when WIDTH=1.
- hit_count:
  - Increments by 1 on each cycle where the final stage is valid and its data is all ones.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by rst.
- in_valid=0 beats:
  - Data still propagates through the internal stages.
  - It never reaches out, out_valid or hit_count.
- X/illegal inputs are not filtered. Operands with in_valid=0 may be X without affecting outputs.
- Parameter checks:
  - LATENCY<1 or WIDTH<1 is a configuration error.
  - Flag it with an elaboration-time check; no runtime behaviour is defined for it.

Test Plan:
- Reset then truth table (WIDTH=1, LATENCY=1): hold rst for 2 cycles, then apply (a,b)=(0,0),(0,1),(1,0),(1,1) with in_valid=1, one beat every 10 cycles -> out=0,0,0,1, each with a single out_valid pulse one edge after capture; hit_count ends at 1.
- Hold behaviour: after the (1,1) beat, apply a=0,b=0 with in_valid=0 for 10 cycles -> out stays 1, out_valid stays 0, hit_count stays 1.
- Multi-bit pipeline (WIDTH=8, LATENCY=3): consecutive beats a=8'hF0,b=8'h3C; a=8'hFF,b=8'hFF; a=8'hAA,b=8'h55 -> out=8'h30, 8'hFF, 8'h00 on 3 consecutive cycles, first appearing 3 edges after the first capture. out_all=0,1,0 and hit_count=1.
- Reset mid-flight (LATENCY=3): assert rst for 1 cycle while 2 valid beats are in flight -> no out_valid pulses follow; out=0 and hit_count=0 after reset.
- Saturation (CNT_W=2): 5 valid beats of all-ones -> hit_count reads 1,2,3,3,3.
- Reset priority: rst=1 together with in_valid=1, a=b=1 -> no output pulse, and out remains 0.
